// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM bus arbiter: SDRAM command encodings,
// arbiter state encoding and the last-grant marker.
package sdram_arbit_pkg;

  localparam int REF_PERIOD_DEF = 780;
  localparam int REF_CNT_W_DEF  = 10;
  localparam int ADDR_W_DEF     = 12;
  localparam int BANK_W_DEF     = 2;

  // {CS,RAS,CAS,WE}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WR    = 5'b01000,
    S_RD    = 5'b10000
  } arb_state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// Engine-side bundle of the SDRAM arbiter: per-engine command paths,
// request/grant/end handshakes and the shared SDRAM pin outputs.
interface sdram_arbit_if #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2
);
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              flag_init_end;

  logic              ref_en;
  logic              ref_req;
  logic [3:0]        ref_cmd;
  logic [ADDR_W-1:0] ref_addr;
  logic              flag_ref_end;

  logic              wr_req;
  logic              wr_en;
  logic              flag_wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;

  logic              rd_req;
  logic              rd_en;
  logic              flag_rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;

  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;
  logic              ref_overrun;

  // Arbiter side
  modport slave (
    input  init_cmd, init_addr, flag_init_end,
    input  ref_cmd, ref_addr, flag_ref_end,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, ref_req, wr_en, rd_en,
    output sdram_cmd, sdram_addr, sdram_bank, ref_overrun
  );

  // Engine / pin side
  modport master (
    output init_cmd, init_addr, flag_init_end,
    output ref_cmd, ref_addr, flag_ref_end,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, ref_req, wr_en, rd_en,
    input  sdram_cmd, sdram_addr, sdram_bank, ref_overrun
  );
endinterface

// File: rtl/sdram_arbit_ref_timer.sv
// Refresh interval timer: free-runs once started, raises ref_req every
// REF_PERIOD clocks and flags an overrun if the previous request is still open.
module sdram_arbit_ref_timer #(
  parameter int REF_PERIOD = 780,
  parameter int REF_CNT_W  = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic clr_i,
  output logic ref_req_o,
  output logic overrun_o
);

  localparam logic [REF_CNT_W-1:0] CntLast = REF_CNT_W'(REF_PERIOD - 1);

  logic                 run_q, run_d;
  logic [REF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 ref_req_q, ref_req_d;
  logic                 overrun_q, overrun_d;
  logic                 wrap;

  always_comb begin
    wrap  = run_q && (cnt_q == CntLast);
    run_d = run_q | start_i;
    cnt_d = cnt_q;
    if (run_q) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    // A completing refresh beats a new request landing in the same cycle
    ref_req_d = ref_req_q;
    if (clr_i)     ref_req_d = 1'b0;
    else if (wrap) ref_req_d = 1'b1;
    overrun_d = overrun_q | (wrap & ref_req_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      ref_req_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      ref_req_q <= ref_req_d;
      overrun_q <= overrun_d;
    end
  end

  assign ref_req_o = ref_req_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sdram_arbit.sv
// Central scheduler for the single SDRAM command/address bus: init, then
// refresh/write/read sharing with round-robin between write and read.
//
// state   | meaning
// S_INIT  | power-up sequence owns the bus
// S_ARBIT | bus idle (NOP), pick next owner
// S_AREF  | refresh engine owns the bus
// S_WR    | write engine owns the bus
// S_RD    | read engine owns the bus
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int REF_CNT_W  = REF_CNT_W_DEF
) (
  input logic          clk_i,
  input logic          rst_ni,
  sdram_arbit_if.slave bus
);

  arb_state_e state_q;
  grant_e     last_q;
  logic       ref_req;
  logic       timer_start;
  logic       timer_clr;

  assign timer_start = (state_q == S_INIT) && bus.flag_init_end;
  assign timer_clr   = (state_q == S_AREF) && bus.flag_ref_end;

  sdram_arbit_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .REF_CNT_W  (REF_CNT_W)
  ) u_ref_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (timer_start),
    .clr_i     (timer_clr),
    .ref_req_o (ref_req),
    .overrun_o (bus.ref_overrun)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      last_q  <= GNT_RD;
    end else begin
      unique case (state_q)
        S_INIT:  if (bus.flag_init_end) state_q <= S_ARBIT;
        S_ARBIT: begin
          if (ref_req)                        state_q <= S_AREF;
          else if (bus.wr_req && bus.rd_req)  state_q <= (last_q == GNT_RD) ? S_WR : S_RD;
          else if (bus.wr_req)                state_q <= S_WR;
          else if (bus.rd_req)                state_q <= S_RD;
        end
        S_AREF:  if (bus.flag_ref_end) state_q <= S_ARBIT;
        S_WR: begin
          if (bus.flag_wr_end) begin
            state_q <= S_ARBIT;
            last_q  <= GNT_WR;
          end
        end
        S_RD: begin
          if (bus.flag_rd_end) begin
            state_q <= S_ARBIT;
            last_q  <= GNT_RD;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.ref_req = ref_req;
  assign bus.ref_en  = (state_q == S_AREF);
  assign bus.wr_en   = (state_q == S_WR);
  assign bus.rd_en   = (state_q == S_RD);

  // S_ARBIT always drives NOP, giving a turnaround cycle between owners
  always_comb begin
    bus.sdram_cmd  = CMD_NOP;
    bus.sdram_addr = '0;
    bus.sdram_bank = '0;
    unique case (state_q)
      S_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      S_AREF: begin
        bus.sdram_cmd  = bus.ref_cmd;
        bus.sdram_addr = bus.ref_addr;
      end
      S_WR: begin
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
        bus.sdram_bank = bus.wr_bank;
      end
      S_RD: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_bank = bus.rd_bank;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized bench for sdram_arbit: engines are emulated, a bus-ownership
// model predicts every cycle's outputs into a queue checked by a monitor.
module tb_sdram_arbit;
  import sdram_arbit_pkg::*;

  localparam int AW     = 12;
  localparam int BW     = 2;
  localparam int PERIOD = 780;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  sdram_arbit_if #(.ADDR_W(AW), .BANK_W(BW)) bus ();

  sdram_arbit #(.REF_PERIOD(PERIOD), .REF_CNT_W(10)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef enum int {O_INIT, O_IDLE, O_REF, O_WR, O_RD} own_e;

  typedef struct {
    logic [2:0]    gnt;   // {ref_en, wr_en, rd_en}
    logic          ref_req;
    logic          overrun;
    logic [3:0]    cmd;
    logic [AW-1:0] addr;
    logic [BW-1:0] bank;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0, pushed = 0, popped = 0, cyc = 0;

  // Reference model: who owns the bus, and refresh due times as
  // multiples of PERIOD counted from the init-done edge.
  own_e m_own     = O_INIT;
  bit   m_timer_on = 1'b0;
  int   m_age     = 0;
  bit   m_pend    = 1'b0;
  bit   m_ovr     = 1'b0;
  bit   m_last_wr = 1'b0;

  int mode = 0;
  bit ref_silent = 1'b0;
  bit strays = 1'b0;
  int init_cnt = 0;

  logic [3:0] init_pool [4];
  logic [3:0] wr_pool [3];
  logic [3:0] rd_pool [3];

  task automatic model_edge();
    own_e nxt;
    bit   due;
    if (!rst_ni) begin
      m_own = O_INIT; m_timer_on = 0; m_age = 0;
      m_pend = 0; m_ovr = 0; m_last_wr = 0;
      return;
    end
    nxt = m_own;
    case (m_own)
      O_INIT: if (bus.flag_init_end) nxt = O_IDLE;
      O_IDLE: begin
        if (m_pend) nxt = O_REF;
        else if (bus.wr_req && bus.rd_req) nxt = m_last_wr ? O_RD : O_WR;
        else if (bus.wr_req) nxt = O_WR;
        else if (bus.rd_req) nxt = O_RD;
      end
      O_REF: if (bus.flag_ref_end) nxt = O_IDLE;
      O_WR: if (bus.flag_wr_end) begin nxt = O_IDLE; m_last_wr = 1; end
      O_RD: if (bus.flag_rd_end) begin nxt = O_IDLE; m_last_wr = 0; end
      default: ;
    endcase
    due = 0;
    if (m_timer_on) begin
      m_age++;
      due = (m_age % PERIOD) == 0;
    end
    if (due && m_pend) m_ovr = 1;
    if (m_own == O_REF && bus.flag_ref_end) m_pend = 0;
    else if (due) m_pend = 1;
    if (m_own == O_INIT && bus.flag_init_end) begin
      m_timer_on = 1; m_age = 0;
    end
    m_own = nxt;
  endtask

  task automatic drive();
    bus.flag_init_end = 0; bus.flag_ref_end = 0;
    bus.flag_wr_end = 0;   bus.flag_rd_end = 0;
    bus.init_cmd  = init_pool[$urandom_range(0, 3)];
    bus.init_addr = AW'($urandom);
    bus.ref_cmd   = ($urandom_range(0, 1) == 0) ? CMD_AREF : CMD_PRE;
    bus.ref_addr  = AW'($urandom);
    bus.wr_cmd    = wr_pool[$urandom_range(0, 2)];
    bus.wr_addr   = AW'($urandom);
    bus.wr_bank   = BW'($urandom);
    bus.rd_cmd    = rd_pool[$urandom_range(0, 2)];
    bus.rd_addr   = AW'($urandom);
    bus.rd_bank   = BW'($urandom);

    if (rst_ni && m_own == O_INIT) begin
      if (init_cnt == 100) bus.flag_init_end = 1;
      init_cnt++;
    end

    case (mode)
      0: begin bus.wr_req = 0; bus.rd_req = 0; end
      1: begin bus.wr_req = 1; bus.rd_req = 1; end
      2: begin
        if ($urandom_range(0, 7) == 0) bus.wr_req = ~bus.wr_req;
        if ($urandom_range(0, 7) == 0) bus.rd_req = ~bus.rd_req;
      end
      default: begin bus.wr_req = 1; bus.rd_req = 0; end
    endcase

    if (m_own == O_WR && $urandom_range(0, 3) == 0) bus.flag_wr_end = 1;
    if (m_own == O_RD && $urandom_range(0, 3) == 0) bus.flag_rd_end = 1;
    if (m_own == O_REF && !ref_silent && $urandom_range(0, 2) == 0) bus.flag_ref_end = 1;
    if (strays) begin
      if (m_own != O_WR && $urandom_range(0, 15) == 0) bus.flag_wr_end = 1;
      if (m_own != O_RD && $urandom_range(0, 15) == 0) bus.flag_rd_end = 1;
      if (m_own != O_REF && $urandom_range(0, 15) == 0) bus.flag_ref_end = 1;
      if (m_own != O_INIT && $urandom_range(0, 15) == 0) bus.flag_init_end = 1;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.gnt     = {m_own == O_REF, m_own == O_WR, m_own == O_RD};
    e.ref_req = m_pend;
    e.overrun = m_ovr;
    e.cmd = CMD_NOP; e.addr = '0; e.bank = '0;
    case (m_own)
      O_INIT: begin e.cmd = bus.init_cmd; e.addr = bus.init_addr; end
      O_REF:  begin e.cmd = bus.ref_cmd;  e.addr = bus.ref_addr; end
      O_WR:   begin e.cmd = bus.wr_cmd;   e.addr = bus.wr_addr; e.bank = bus.wr_bank; end
      O_RD:   begin e.cmd = bus.rd_cmd;   e.addr = bus.rd_addr; e.bank = bus.rd_bank; end
      default: ;
    endcase
    e.cyc = cyc;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic step(input bit rst_v);
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    rst_ni = rst_v;
    if (!rst_v) init_cnt = 0;
    drive();
    push_expect();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
    end
  endtask

  // Monitor: compares every cycle's DUT outputs against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        chk("grants", 32'({bus.ref_en, bus.wr_en, bus.rd_en}), 32'(e.gnt), e.cyc);
        chk("ref_req", 32'(bus.ref_req), 32'(e.ref_req), e.cyc);
        chk("ref_overrun", 32'(bus.ref_overrun), 32'(e.overrun), e.cyc);
        chk("sdram_bus", 32'({bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank}),
            32'({e.cmd, e.addr, e.bank}), e.cyc);
      end
    end
  end

  initial begin
    int n;
    init_pool = '{CMD_MRS, CMD_PRE, CMD_AREF, CMD_NOP};
    wr_pool   = '{CMD_ACT, CMD_WR, CMD_PRE};
    rd_pool   = '{CMD_ACT, CMD_RD, CMD_PRE};
    bus.wr_req = 0; bus.rd_req = 0;
    drive();

    // Reset, init done at cycle ~100, idle through the first refresh
    repeat (3) step(1'b0);
    repeat (900) step(1'b1);
    // Both engines requesting: strict alternation, write first
    mode = 1;
    repeat (300) step(1'b1);
    // Random traffic with stray end pulses
    mode = 2; strays = 1;
    repeat (3000) step(1'b1);
    // Silent refresh engine long enough to miss a whole interval
    ref_silent = 1;
    repeat (2 * PERIOD + 20) step(1'b1);
    ref_silent = 0;
    repeat (200) step(1'b1);
    // Reset in the middle of a write
    mode = 3; strays = 0;
    n = 0;
    while (m_own != O_WR && n < 500) begin
      step(1'b1);
      n++;
    end
    step(1'b0);
    repeat (150) step(1'b1);
    mode = 2; strays = 1;
    repeat (1500) step(1'b1);

    repeat (3) @(posedge clk);
    checks++;
    if (popped != pushed || exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d compared expected %0d", popped, pushed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
